// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, bo set when y > x.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor (a - b - bin), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_full_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d1, bo1, d, bo2, bo;
  logic             accept_c, last_c;

  assign accept_c = in_valid && (state == ST_IDLE);
  assign last_c   = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));

  // Full subtractor from two half subtractors; second stage absorbs the borrow
  half_subtractor u_hs1 (.x(a_sr[0]), .y(b_sr[0]), .d(d1), .bo(bo1));
  half_subtractor u_hs2 (.x(d1),      .y(br),      .d(d),  .bo(bo2));
  assign bo = bo1 | bo2;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (in_valid)  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_c)    state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Operand/result shift registers; diff_sr and br double as the result holders
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      br      <= 1'b0;
      cnt     <= '0;
    end else if (accept_c) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      br      <= bo;
      diff_sr <= {d, diff_sr[WIDTH-1:1]};
      if (!last_c) cnt <= cnt + CW'(1);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb, ovf_q;

  // Sign bits captured at accept; the final serial bit is the result sign
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept_c) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_c) begin
      ovf_q <= (a_msb != b_msb) && (d != a_msb);
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = rst_n && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign diff      = diff_sr;
  assign bout      = br;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed and random self-checking bench for serial_full_subtractor (WIDTH=8).
module tb_serial_full_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, measure latency, optional stall, then handshake
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] ediff, input logic ebout, input int stall,
                        input string tag);
    int lat;
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * W) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(W));
    chk({tag, ".diff"}, 32'(diff), 32'(ediff));
    chk({tag, ".bout"}, 32'(bout), 32'(ebout));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      step();
      chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".stall_diff"}, 32'(diff), 32'(ediff));
      chk({tag, ".stall_bout"}, 32'(bout), 32'(ebout));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".post_diff"}, 32'(diff), 32'(ediff));
  endtask

  initial begin
    logic [W-1:0] ra, rb, ed;
    logic         rbin, eb;
    int           seen;

    // Power-on reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.bout", 32'(bout), 32'd0);
    chk("rst.in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_high", 32'(in_ready), 32'd1);

    // Basic subtraction
    run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 0, "t2");

    // Reset in the middle of a SHIFT sequence
    a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.diff", 32'(diff), 32'd0);
    chk("midrst.bout", 32'(bout), 32'd0);
    chk("midrst.in_ready_low", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst.in_ready_high", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("midrst.no_result", 32'(seen), 32'd0);

    // Wrap and borrow-in boundaries
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, "wrap");
    run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1, "bin_full");
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, "equal");

    // Backpressure with in_valid held high
    run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 5, "bp");

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 2, "ovf1");
    chk("ovf1.ovf", 32'(ovf), 32'd1);
    run_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 0, "ovf0");
    chk("ovf0.ovf", 32'(ovf), 32'd0);
`endif

    // Random operands with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      {eb, ed} = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
      run_op(ra, rb, rbin, ed, eb, int'($urandom_range(0, 3)), "rand");
`ifdef SERIAL_SUB_OVF_EN
      chk("rand.ovf", 32'(ovf), 32'((ra[W-1] != rb[W-1]) && (ed[W-1] != ra[W-1])));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
